mastermind_core: RTL and testbench

Parametrised scoring and game-state engine for the Mastermind design. It accepts a secret code and a stream of guesses, scores each guess as exact and partial matches, and keeps a per-turn history of guesses and scores. It declares the game won or lost. It sits between the guess/history front end and the feedback/seven-segment path, and generalises peg count, colour count and turn limit.

---
 rtl/mm_pkg.sv | 36 +++
 rtl/mm_history.sv | 50 +++++
 rtl/mastermind_core.sv | 202 ++++++++++++++++++++
 tb/tb_mastermind_core.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared definitions for the Mastermind scoring engine.
//   - default parameter values
//   - FSM state encoding used by mastermind_core
//   - peg_at(): extracts peg idx from a packed code/guess vector
package mm_pkg;

    localparam int DEF_NUM_PEGS  = 4;
    localparam int DEF_COLOR_W   = 3;
    localparam int DEF_MAX_TURNS = 8;

    // Widest code vector and peg the helper accepts; callers zero-extend
    // their vectors to CODE_MAX_W and truncate the result to their COLOR_W.
    localparam int CODE_MAX_W = 64;
    localparam int PEG_MAX_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        EXACT,
        TALLY,
        RESULT,
        OVER
    } state_t;

    // Peg idx lives at [idx*color_w +: color_w].
    function automatic logic [PEG_MAX_W-1:0] peg_at(
        input logic [CODE_MAX_W-1:0] vec,
        input int                    idx,
        input int                    color_w
    );
        logic [CODE_MAX_W-1:0] shifted;
        shifted = vec >> (idx * color_w);
        return shifted[PEG_MAX_W-1:0] & PEG_MAX_W'((1 << color_w) - 1);
    endfunction

endpackage

// File: rtl/mm_history.sv
// mm_history: per-turn history store for mastermind_core.
//   clk, reset : clock and asynchronous active-high reset
//   we, wr_idx, wr_data : write port (one entry per scored guess)
//   rd_idx  : read index, sampled every cycle
//   turn    : number of valid entries; indices >= turn read back as zero
//   rd_data : read data, one cycle after rd_idx
// The storage array has no reset so it can map onto block RAM; a new game
// "empties" the history simply because turn returns to zero.
module mm_history #(
    parameter int DATA_W = 18,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [IDX_W-1:0]  turn,
    output logic [DATA_W-1:0] rd_data
);

    // Sized to the full index range so every rd_idx value addresses a
    // legal entry; only the first MAX_TURNS entries are ever written.
    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] mem_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
        mem_q <= mem[rd_idx];
    end

    // Validity is judged against the turn count before any coincident
    // write, so the entry being written this cycle still reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= (rd_idx < turn);
        end
    end

    assign rd_data = valid_q ? mem_q : '0;

endmodule

// File: rtl/mastermind_core.sv
// mastermind_core: Mastermind scoring and game-state engine.
//   clk, reset        : clock, asynchronous active-high reset
//   new_game          : abort everything and return to IDLE
//   code_load, code   : load the secret (IDLE only)
//   guess_valid/ready : guess handshake, guess_ready high only in READY
//   result_valid      : one-cycle pulse with exact/partial/turn/won/lost
//   exact, partial    : score of the last guess, held until the next one
//   turn              : guesses scored in this game
//   won, lost         : sticky game outcome
//   hist_rd_idx       : history read index; hist_* valid one cycle later
// A guess is scored as: EXACT counts positional matches, TALLY spends one
// cycle per colour summing min(count in code, count in guess), and the
// last TALLY cycle registers the results so they appear in RESULT.
module mastermind_core
    import mm_pkg::*;
#(
    parameter int NUM_PEGS  = DEF_NUM_PEGS,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int MAX_TURNS = DEF_MAX_TURNS,
    parameter int CODE_W    = NUM_PEGS * COLOR_W,
    parameter int CNT_W     = $clog2(NUM_PEGS + 1),
    parameter int TURN_W    = $clog2(MAX_TURNS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic              code_load,
    input  logic [CODE_W-1:0] code,
    input  logic              guess_valid,
    input  logic [CODE_W-1:0] guess,
    output logic              guess_ready,
    output logic              result_valid,
    output logic [CNT_W-1:0]  exact,
    output logic [CNT_W-1:0]  partial,
    output logic [TURN_W-1:0] turn,
    output logic              won,
    output logic              lost,
    input  logic [TURN_W-1:0] hist_rd_idx,
    output logic [CODE_W-1:0] hist_guess,
    output logic [CNT_W-1:0]  hist_exact,
    output logic [CNT_W-1:0]  hist_partial
);

    localparam int NCOL   = 2 ** COLOR_W;
    localparam int HIST_W = CODE_W + 2 * CNT_W;

    state_t              state;
    logic [CODE_W-1:0]   code_reg;
    logic [CODE_W-1:0]   guess_reg;
    logic [CNT_W-1:0]    exact_reg;
    logic [CNT_W-1:0]    sum_reg;
    logic [COLOR_W-1:0]  colour_reg;

    logic [COLOR_W-1:0]  code_peg  [NUM_PEGS];
    logic [COLOR_W-1:0]  guess_peg [NUM_PEGS];

    logic [CNT_W-1:0]    exact_now;
    logic [CNT_W-1:0]    code_cnt;
    logic [CNT_W-1:0]    guess_cnt;
    logic [CNT_W-1:0]    tally_min;
    logic [CNT_W-1:0]    sum_final;
    logic [CNT_W-1:0]    partial_now;
    logic [TURN_W-1:0]   turn_next;
    logic                last_colour;
    logic                hist_we;
    logic [HIST_W-1:0]   hist_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PEGS; gi++) begin : g_peg
            assign code_peg[gi]  = COLOR_W'(peg_at(CODE_MAX_W'(code_reg), gi, COLOR_W));
            assign guess_peg[gi] = COLOR_W'(peg_at(CODE_MAX_W'(guess_reg), gi, COLOR_W));
        end
    endgenerate

    // Positional matches plus per-colour popcounts for the colour under test.
    always_comb begin
        exact_now = '0;
        code_cnt  = '0;
        guess_cnt = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (guess_peg[i] == code_peg[i]) begin
                exact_now = exact_now + CNT_W'(1);
            end
            if (code_peg[i] == colour_reg) begin
                code_cnt = code_cnt + CNT_W'(1);
            end
            if (guess_peg[i] == colour_reg) begin
                guess_cnt = guess_cnt + CNT_W'(1);
            end
        end
        tally_min   = (code_cnt < guess_cnt) ? code_cnt : guess_cnt;
        sum_final   = sum_reg + tally_min;
        partial_now = sum_final - exact_reg;
        turn_next   = turn + TURN_W'(1);
        last_colour = (colour_reg == COLOR_W'(NCOL - 1));
        // A coincident new_game aborts the guess, so nothing is recorded.
        hist_we     = (state == TALLY) && last_colour && !new_game;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            code_reg     <= '0;
            guess_reg    <= '0;
            exact_reg    <= '0;
            sum_reg      <= '0;
            colour_reg   <= '0;
            guess_ready  <= 1'b0;
            result_valid <= 1'b0;
            exact        <= '0;
            partial      <= '0;
            turn         <= '0;
            won          <= 1'b0;
            lost         <= 1'b0;
        end else if (new_game) begin
            state        <= IDLE;
            guess_ready  <= 1'b0;
            result_valid <= 1'b0;
            exact        <= '0;
            partial      <= '0;
            turn         <= '0;
            won          <= 1'b0;
            lost         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (code_load) begin
                        code_reg    <= code;
                        guess_ready <= 1'b1;
                        state       <= READY;
                    end
                end
                READY: begin
                    if (guess_valid) begin
                        guess_reg   <= guess;
                        guess_ready <= 1'b0;
                        state       <= EXACT;
                    end
                end
                EXACT: begin
                    exact_reg  <= exact_now;
                    sum_reg    <= '0;
                    colour_reg <= '0;
                    state      <= TALLY;
                end
                TALLY: begin
                    sum_reg    <= sum_final;
                    colour_reg <= colour_reg + COLOR_W'(1);
                    if (last_colour) begin
                        // Results are registered here so they are visible
                        // throughout the RESULT cycle.
                        exact        <= exact_reg;
                        partial      <= partial_now;
                        result_valid <= 1'b1;
                        turn         <= turn_next;
                        if (exact_reg == CNT_W'(NUM_PEGS)) begin
                            won <= 1'b1;
                        end else if (turn_next == TURN_W'(MAX_TURNS)) begin
                            lost <= 1'b1;
                        end
                        state <= RESULT;
                    end
                end
                RESULT: begin
                    if (won || lost) begin
                        state <= OVER;
                    end else begin
                        guess_ready <= 1'b1;
                        state       <= READY;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mm_history #(
        .DATA_W (HIST_W),
        .IDX_W  (TURN_W)
    ) u_history (
        .clk     (clk),
        .reset   (reset),
        .we      (hist_we),
        .wr_idx  (turn),
        .wr_data ({guess_reg, exact_reg, partial_now}),
        .rd_idx  (hist_rd_idx),
        .turn    (turn),
        .rd_data (hist_data)
    );

    assign hist_guess   = hist_data[HIST_W-1 -: CODE_W];
    assign hist_exact   = hist_data[2*CNT_W-1 -: CNT_W];
    assign hist_partial = hist_data[CNT_W-1:0];

endmodule

// File: tb/tb_mastermind_core.sv
// Directed bench for mastermind_core: default configuration plus a second
// instance with 6 pegs, 2-bit colours and 10 turns.
module tb_mastermind_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // Default instance (4 pegs x 3 bits, 8 turns).
    logic        new_game = 1'b0, code_load = 1'b0, guess_valid = 1'b0;
    logic [11:0] code = '0, guess = '0;
    logic        guess_ready, result_valid, won, lost;
    logic [2:0]  exact, partial, hist_exact, hist_partial;
    logic [3:0]  turn;
    logic [3:0]  hist_rd_idx = '0;
    logic [11:0] hist_guess;

    // Alternate instance (6 pegs x 2 bits, 10 turns).
    logic        new_game_b = 1'b0, code_load_b = 1'b0, guess_valid_b = 1'b0;
    logic [11:0] code_b = '0, guess_b = '0;
    logic        guess_ready_b, result_valid_b, won_b, lost_b;
    logic [2:0]  exact_b, partial_b, hist_exact_b, hist_partial_b;
    logic [3:0]  turn_b;
    logic [3:0]  hist_rd_idx_b = '0;
    logic [11:0] hist_guess_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mastermind_core u_dut (
        .clk(clk), .reset(reset), .new_game(new_game), .code_load(code_load),
        .code(code), .guess_valid(guess_valid), .guess(guess),
        .guess_ready(guess_ready), .result_valid(result_valid),
        .exact(exact), .partial(partial), .turn(turn), .won(won), .lost(lost),
        .hist_rd_idx(hist_rd_idx), .hist_guess(hist_guess),
        .hist_exact(hist_exact), .hist_partial(hist_partial)
    );

    mastermind_core #(.NUM_PEGS(6), .COLOR_W(2), .MAX_TURNS(10)) u_dut_b (
        .clk(clk), .reset(reset), .new_game(new_game_b), .code_load(code_load_b),
        .code(code_b), .guess_valid(guess_valid_b), .guess(guess_b),
        .guess_ready(guess_ready_b), .result_valid(result_valid_b),
        .exact(exact_b), .partial(partial_b), .turn(turn_b), .won(won_b), .lost(lost_b),
        .hist_rd_idx(hist_rd_idx_b), .hist_guess(hist_guess_b),
        .hist_exact(hist_exact_b), .hist_partial(hist_partial_b)
    );

    function automatic logic [11:0] p4(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic logic [11:0] p6(input int a, input int b, input int c,
                                       input int d, input int e, input int f);
        return {2'(f), 2'(e), 2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    task automatic do_new_game();
        @(negedge clk); new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
    endtask

    task automatic load_code(input logic [11:0] c);
        @(negedge clk); code_load = 1'b1; code = c;
        @(negedge clk); code_load = 0;
        total++;
        if (guess_ready !== 1'b1) begin
            bad++; $display("FAIL load_ready: got %0b want 1", guess_ready);
        end
    endtask

    // Offers one guess, waits for result_valid and checks latency and score
    // in the RESULT cycle; returns at the cycle after RESULT.
    task automatic score(input logic [11:0] g, input int ee, input int ep,
                         input int et, input int ew, input int el, input string name);
        int lat;
        @(negedge clk); guess_valid = 1'b1; guess = g;
        @(negedge clk); guess_valid = 1'b0; lat = 1;
        while (result_valid !== 1'b1 && lat < 40) begin
            @(negedge clk); lat++;
        end
        $display("txn %s: guess=%h exact=%0d partial=%0d turn=%0d lat=%0d",
                 name, g, exact, partial, turn, lat);
        total++;
        if (lat != 10) begin bad++; $display("FAIL %s_latency: got %0d want 10", name, lat); end
        total++;
        if (exact !== 3'(ee)) begin bad++; $display("FAIL %s_exact: got %0d want %0d", name, exact, ee); end
        total++;
        if (partial !== 3'(ep)) begin bad++; $display("FAIL %s_partial: got %0d want %0d", name, partial, ep); end
        total++;
        if (turn !== 4'(et)) begin bad++; $display("FAIL %s_turn: got %0d want %0d", name, turn, et); end
        total++;
        if (won !== 1'(ew) || lost !== 1'(el)) begin
            bad++; $display("FAIL %s_outcome: got won=%0b lost=%0b want won=%0d lost=%0d", name, won, lost, ew, el);
        end
        total++;
        if (guess_ready !== 1'b0) begin bad++; $display("FAIL %s_ready_in_result: got %0b want 0", name, guess_ready); end
        @(negedge clk);
        total++;
        if (result_valid !== 1'b0) begin bad++; $display("FAIL %s_pulse: result_valid got %0b want 0", name, result_valid); end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk); reset = 1'b0;
        @(negedge clk);
        total++;
        if ({guess_ready, result_valid, won, lost} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {guess_ready, result_valid, won, lost});
        end
        total++;
        if ({exact, partial, turn} !== 10'b0) begin
            bad++; $display("FAIL reset_counts: got %h want 0", {exact, partial, turn});
        end
        total++;
        if ({hist_guess, hist_exact, hist_partial} !== 18'b0) begin
            bad++; $display("FAIL reset_hist: got %h want 0", {hist_guess, hist_exact, hist_partial});
        end
    endtask

    task automatic test_win();
        load_code(p4(1, 2, 3, 4));
        score(p4(1, 2, 3, 4), 4, 0, 1, 1, 0, "win");
        repeat (3) @(negedge clk);
        total++;
        if (guess_ready !== 1'b0 || won !== 1'b1) begin
            bad++; $display("FAIL win_over: got ready=%0b won=%0b want ready=0 won=1", guess_ready, won);
        end
    endtask

    task automatic test_all_partial();
        do_new_game();
        load_code(p4(1, 1, 2, 2));
        score(p4(2, 2, 1, 1), 0, 4, 1, 0, 0, "allpart");
        total++;
        if (guess_ready !== 1'b1) begin bad++; $display("FAIL allpart_ready: got %0b want 1", guess_ready); end
    endtask

    task automatic test_mixed();
        do_new_game();
        load_code(p4(1, 1, 2, 3));
        score(p4(1, 2, 1, 1), 1, 2, 1, 0, 0, "mixed");
    endtask

    task automatic test_history();
        logic [11:0] eg [4];
        int          ee [4];
        int          ep [4];
        eg[0] = p4(1, 2, 1, 1); ee[0] = 1; ep[0] = 2;
        eg[1] = p4(0, 0, 0, 0); ee[1] = 0; ep[1] = 0;
        eg[2] = p4(3, 2, 1, 1); ee[2] = 0; ep[2] = 4;
        eg[3] = '0;             ee[3] = 0; ep[3] = 0;
        do_new_game();
        load_code(p4(1, 1, 2, 3));
        for (int t = 0; t < 3; t++) begin
            score(eg[t], ee[t], ep[t], t + 1, 0, 0, "hist_guess");
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); hist_rd_idx = 4'(i);
            #1;
            // Registered read: the previous entry is still on the outputs.
            if (i == 3) begin
                total++;
                if (hist_guess !== eg[2]) begin
                    bad++; $display("FAIL hist_latency: got %h want %h", hist_guess, eg[2]);
                end
            end
            @(negedge clk);
            $display("txn hist_read idx=%0d guess=%h exact=%0d partial=%0d", i, hist_guess, hist_exact, hist_partial);
            total++;
            if (hist_guess !== eg[i] || hist_exact !== 3'(ee[i]) || hist_partial !== 3'(ep[i])) begin
                bad++; $display("FAIL hist_entry%0d: got %h/%0d/%0d want %h/%0d/%0d",
                                i, hist_guess, hist_exact, hist_partial, eg[i], ee[i], ep[i]);
            end
        end
    endtask

    task automatic test_lose();
        bit seen;
        do_new_game();
        load_code(p4(7, 7, 7, 7));
        for (int t = 1; t <= 8; t++) begin
            score(p4(0, 0, 0, 0), 0, 0, t, 0, (t == 8) ? 1 : 0, "lose");
        end
        @(negedge clk); guess_valid = 1'b1; guess = p4(7, 7, 7, 7);
        @(negedge clk); guess_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen || turn !== 4'd8 || lost !== 1'b1) begin
            bad++; $display("FAIL lose_ninth: got seen=%0b turn=%0d lost=%0b want 0/8/1", seen, turn, lost);
        end
        do_new_game();
        total++;
        if (turn !== 4'd0 || lost !== 1'b0 || guess_ready !== 1'b0) begin
            bad++; $display("FAIL lose_newgame: got turn=%0d lost=%0b ready=%0b want 0/0/0", turn, lost, guess_ready);
        end
        hist_rd_idx = 4'd0;
        @(negedge clk);
        total++;
        if (hist_guess !== 12'd0 || hist_exact !== 3'd0) begin
            bad++; $display("FAIL lose_hist_cleared: got %h/%0d want 0/0", hist_guess, hist_exact);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_new_game();
        hist_rd_idx = 4'd0;
        load_code(p4(1, 2, 3, 4));
        score(p4(1, 2, 0, 0), 2, 0, 1, 0, 0, "pre_reset");
        @(negedge clk); guess_valid = 1'b1; guess = p4(4, 3, 2, 1);
        @(negedge clk); guess_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        total++;
        if ({guess_ready, result_valid, won, lost} !== 4'b0 || {exact, partial, turn} !== 10'b0) begin
            bad++; $display("FAIL midreset_outputs: got flags=%b counts=%h want 0", {guess_ready, result_valid, won, lost}, {exact, partial, turn});
        end
        total++;
        if ({hist_guess, hist_exact, hist_partial} !== 18'b0) begin
            bad++; $display("FAIL midreset_hist: got %h want 0", {hist_guess, hist_exact, hist_partial});
        end
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL midreset_no_result: got result_valid=1 want none"); end
        load_code(p4(4, 3, 2, 1));
        score(p4(4, 3, 2, 1), 4, 0, 1, 1, 0, "post_reset");
    endtask

    task automatic test_alt_config();
        int lat;
        @(negedge clk); code_load_b = 1'b1; code_b = p6(0, 1, 2, 3, 0, 1);
        @(negedge clk); code_load_b = 1'b0; guess_valid_b = 1'b1; guess_b = p6(1, 0, 2, 3, 3, 3);
        @(negedge clk); guess_valid_b = 1'b0; lat = 1;
        while (result_valid_b !== 1'b1 && lat < 40) begin
            @(negedge clk); lat++;
        end
        $display("txn alt: exact=%0d partial=%0d turn=%0d lat=%0d", exact_b, partial_b, turn_b, lat);
        total++;
        if (lat != 6) begin bad++; $display("FAIL alt_latency: got %0d want 6", lat); end
        total++;
        if (exact_b !== 3'd2 || partial_b !== 3'd2 || turn_b !== 4'd1) begin
            bad++; $display("FAIL alt_score: got %0d/%0d/%0d want 2/2/1", exact_b, partial_b, turn_b);
        end
        hist_rd_idx_b = 4'd0;
        @(negedge clk);
        total++;
        if (hist_guess_b !== p6(1, 0, 2, 3, 3, 3) || hist_exact_b !== 3'd2 || hist_partial_b !== 3'd2) begin
            bad++; $display("FAIL alt_hist0: got %h/%0d/%0d want %h/2/2", hist_guess_b, hist_exact_b, hist_partial_b, p6(1, 0, 2, 3, 3, 3));
        end
        hist_rd_idx_b = 4'd1;
        @(negedge clk);
        total++;
        if ({hist_guess_b, hist_exact_b, hist_partial_b} !== 18'b0) begin
            bad++; $display("FAIL alt_hist1: got %h want 0", {hist_guess_b, hist_exact_b, hist_partial_b});
        end
    endtask

    initial begin
        test_reset();
        test_win();
        test_all_partial();
        test_mixed();
        test_history();
        test_lose();
        test_reset_mid();
        test_alt_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
